fp_mant_seg_adder: RTL and testbench
====================================

// Module: fp_mant_seg_adder
// PURPOSE
//  Mantissa adder callee for the single-precision add controller. Adds two
//  24-bit aligned mantissas (operand 2 already complemented by the caller for
//  effective subtraction) over several cycles, one SEG-bit slice per cycle.
//  Returns the 24-bit sum and carry-out via a valid/ack handshake.
//  Sits directly downstream of the adder control FSM (AdderState).
// PARAMETERS
//  WIDTH  24  operand/sum width; must be a multiple of SEG
//  SEG    8   slice width added per cycle; NSEG = WIDTH/SEG compute cycles
// PORTS
//  CLK             in   1      clock, all flops on rising edge
//  RSTn            in   1      asynchronous active-low reset
//  Adder_datain1   in   WIDTH  operand 1 (larger-exponent mantissa)
//  Adder_datain2   in   WIDTH  operand 2 (shifted, possibly complemented)
//  Adder_valid     in   1      request; held high, data stable, until ack seen
//  Adder_dataout   out  WIDTH  registered sum
//  Adder_carryout  out  1      registered carry out of MSB slice
//  Adder_Exc       out  2      00 ok; 01 operands changed mid-add; 10,11 unused
//  Adder_ack       out  1      one-cycle completion pulse
//  Adder_busy      out  1      high in every state except IDLE
// BEHAVIOUR
//  Reset (async, RSTn=0): state IDLE; dataout, carryout, Exc, ack, busy = 0;
//   slice counter, carry and captured operands = 0. Reset mid-add discards it.
//  All outputs registered; no combinational path from inputs to outputs.
//  FSM: IDLE -> ADD -> DONE -> WAIT_LOW -> IDLE.
//   IDLE: Adder_valid=1 at an edge -> capture both operands, cnt=0, cin=0,
//     clear Exc, go to ADD.
//   ADD: each edge adds slice cnt (bits cnt*SEG +: SEG) of captured operands
//     plus cin into dataout slice; cin <= slice carry; cnt++.
//     After slice NSEG-1: carryout <= final carry, go to DONE.
//     Adder_valid=0 in ADD -> abort: go to IDLE, no ack, outputs keep their
//     values.
//     Inputs != captured while valid=1 -> Exc <= 01 (sticky until the next
//     capture); computation continues on captured values.
//   DONE: ack=1 for exactly this cycle; dataout/carryout/Exc final and stable.
//     Next edge -> WAIT_LOW.
//   WAIT_LOW: ack=0; wait for Adder_valid=0, then IDLE. Prevents a re-launch
//     while the caller's valid is still high (caller drops it a cycle after
//     ack).
//  Latency: valid sampled at edge E -> ack high in the cycle after edge
//   E+NSEG (4 cycles at defaults). Throughput: one add per NSEG+3 cycles
//   minimum.
//  Outputs hold until the next capture; dataout slices above the current cnt
//   keep stale values during ADD (caller reads only on ack).
//  Arithmetic: modulo 2^WIDTH, unsigned; carry-out from the MSB slice only.
//   Intermediate carries never leave the block.
//  Simultaneous valid rise and reset: reset wins; no capture.
// STRUCTURE
//  Shared package fp_pkg:
//   - state enum fp_madd_state_t {IDLE, ADD, DONE, WAIT_LOW}
//   - Exc code constants EXC_MADD_OK=2'b00, EXC_MADD_UNSTABLE=2'b01
//   - default WIDTH/SEG localparams
//  One sub-module: fp_seg_add, a combinational SEG-bit adder
//   ({cout,sum} = a+b+cin), instantiated once and muxed by cnt.
// TESTING
//  1. 24'h123456 + 24'h0ABCDE, valid held -> ack 4 cycles later;
//     dataout=24'h1CF134, carry=0, Exc=00.
//  2. 24'hFFFFFF + 24'h000001 -> dataout=24'h000000, carry=1; proves carry
//     ripples across all 3 slices.
//  3. 24'h800000 + 24'h800000 -> dataout=0, carry=1.
//     Keep valid high 2 cycles after ack -> no second ack until valid low and
//     re-raised.
//  4. Start 24'h000010 + 24'h000020; change datain2 to 24'h000030 in ADD ->
//     ack with dataout=24'h000030, Exc=01.
//  5. Drop valid after first ADD edge -> returns to IDLE, no ack, busy=0 next
//     cycle. New request then completes normally.
//  6. Assert RSTn=0 mid-ADD (between edges) -> all outputs 0 immediately.
//     After release, no ack until a new valid.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared types and constants for the floating-point datapath blocks.
// The mantissa segment adder uses the state enum, the Exc codes and the default widths.
package fp_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ADD      = 2'd1,
    DONE     = 2'd2,
    WAIT_LOW = 2'd3
  } fp_madd_state_t;

  localparam logic [1:0] EXC_MADD_OK       = 2'b00;
  localparam logic [1:0] EXC_MADD_UNSTABLE = 2'b01;

  localparam int MADD_WIDTH = 24;
  localparam int MADD_SEG   = 8;

endpackage

// File: rtl/fp_seg_add.sv
// Combinational SEG-bit slice adder: {cout, sum} = a + b + cin.
module fp_seg_add #(
  parameter int SEG = 8
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, cin};

endmodule

// File: rtl/fp_mant_seg_adder.sv
// Multi-cycle mantissa adder: adds two captured WIDTH-bit operands one SEG-bit
// slice per cycle and reports sum, carry-out and an operand-stability flag.
module fp_mant_seg_adder
  import fp_pkg::*;
#(
  parameter int WIDTH = MADD_WIDTH,
  parameter int SEG   = MADD_SEG
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic [WIDTH-1:0] Adder_datain1,
  input  logic [WIDTH-1:0] Adder_datain2,
  input  logic             Adder_valid,
  output logic [WIDTH-1:0] Adder_dataout,
  output logic             Adder_carryout,
  output logic [1:0]       Adder_Exc,
  output logic             Adder_ack,
  output logic             Adder_busy,
  output fp_madd_state_t   dbg_state
);

  localparam int NSEG = WIDTH / SEG;
  localparam int CW   = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSEG - 1);

  // Handshake: caller raises Adder_valid with stable data and holds it until
  // it sees the one-cycle Adder_ack; dropping valid before ack aborts the add.
  fp_madd_state_t state_q, state_n;

  logic [WIDTH-1:0] op1_q, op2_q;
  logic [CW-1:0]    cnt_q;
  logic             cin_q;
  logic             capture, do_slice, operands_changed;
  logic [SEG-1:0]   seg_a, seg_b, seg_sum;
  logic             seg_cout;

  assign seg_a            = op1_q[cnt_q*SEG +: SEG];
  assign seg_b            = op2_q[cnt_q*SEG +: SEG];
  assign operands_changed = (Adder_datain1 != op1_q) || (Adder_datain2 != op2_q);
  assign dbg_state        = state_q;

  fp_seg_add #(.SEG(SEG)) u_seg_add (
    .a    (seg_a),
    .b    (seg_b),
    .cin  (cin_q),
    .sum  (seg_sum),
    .cout (seg_cout)
  );

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) state_q <= IDLE;
    else       state_q <= state_n;
  end

  always_comb begin
    state_n  = state_q;
    capture  = 1'b0;
    do_slice = 1'b0;
    case (state_q)
      IDLE: begin
        if (Adder_valid) begin
          state_n = ADD;
          capture = 1'b1;
        end
      end
      ADD: begin
        if (!Adder_valid) begin
          state_n = IDLE;
        end else begin
          do_slice = 1'b1;
          if (cnt_q == LAST) state_n = DONE;
        end
      end
      DONE:     state_n = WAIT_LOW;
      WAIT_LOW: if (!Adder_valid) state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      op1_q          <= '0;
      op2_q          <= '0;
      cnt_q          <= '0;
      cin_q          <= 1'b0;
      Adder_dataout  <= '0;
      Adder_carryout <= 1'b0;
      Adder_Exc      <= EXC_MADD_OK;
      Adder_ack      <= 1'b0;
      Adder_busy     <= 1'b0;
    end else begin
      if (capture) begin
        op1_q     <= Adder_datain1;
        op2_q     <= Adder_datain2;
        cnt_q     <= '0;
        cin_q     <= 1'b0;
        Adder_Exc <= EXC_MADD_OK;
      end
      if (do_slice) begin
        Adder_dataout[cnt_q*SEG +: SEG] <= seg_sum;
        cin_q <= seg_cout;
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == LAST) Adder_carryout <= seg_cout;
        // Sticky until the next capture; the add itself uses the captured copy.
        if (operands_changed) Adder_Exc <= EXC_MADD_UNSTABLE;
      end
      Adder_ack  <= (state_n == DONE);
      Adder_busy <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_fp_mant_seg_adder.sv
// Directed bench for fp_mant_seg_adder: hand-computed sums, latency,
// handshake, abort, operand-change flag and asynchronous reset.
module tb_fp_mant_seg_adder;
  import fp_pkg::*;

  localparam int W = 24;

  logic          CLK;
  logic          RSTn;
  logic [W-1:0]  Adder_datain1, Adder_datain2;
  logic          Adder_valid;
  logic [W-1:0]  Adder_dataout;
  logic          Adder_carryout;
  logic [1:0]    Adder_Exc;
  logic          Adder_ack;
  logic          Adder_busy;
  fp_madd_state_t dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  logic [W:0] exp_q[$];

  fp_mant_seg_adder dut (
    .CLK            (CLK),
    .RSTn           (RSTn),
    .Adder_datain1  (Adder_datain1),
    .Adder_datain2  (Adder_datain2),
    .Adder_valid    (Adder_valid),
    .Adder_dataout  (Adder_dataout),
    .Adder_carryout (Adder_carryout),
    .Adder_Exc      (Adder_Exc),
    .Adder_ack      (Adder_ack),
    .Adder_busy     (Adder_busy),
    .dbg_state      (dbg_state)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W:0] exp);
    @(negedge CLK);
    Adder_datain1 = a;
    Adder_datain2 = b;
    Adder_valid   = 1'b1;
    exp_q.push_back(exp);
  endtask

  // Counts edges until ack is seen; start gives edges already consumed.
  task automatic wait_ack(input int start, output int lat);
    lat = start;
    for (int i = 0; i < 20; i++) begin
      tick();
      lat++;
      if (Adder_ack) return;
    end
    check("ack_timeout", 32'(lat), 32'd4);
  endtask

  task automatic score(input string tag, input logic [1:0] exc_exp);
    logic [W:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_sum"},   32'(Adder_dataout),  32'(e[W-1:0]));
    check({tag, "_carry"}, 32'(Adder_carryout), 32'(e[W]));
    check({tag, "_exc"},   32'(Adder_Exc),      32'(exc_exp));
  endtask

  task automatic release_valid();
    @(negedge CLK);
    Adder_valid = 1'b0;
  endtask

  int lat;

  initial begin
    RSTn = 1'b0;
    Adder_valid = 1'b0;
    Adder_datain1 = '0;
    Adder_datain2 = '0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_dataout", 32'(Adder_dataout), 32'd0);
    check("rst_carry",   32'(Adder_carryout), 32'd0);
    check("rst_exc",     32'(Adder_Exc), 32'd0);
    check("rst_ack",     32'(Adder_ack), 32'd0);
    check("rst_busy",    32'(Adder_busy), 32'd0);
    check("rst_state",   32'(dbg_state), 32'(IDLE));
    @(negedge CLK);
    RSTn = 1'b1;

    // 1: basic add and latency
    launch(24'h123456, 24'h0ABCDE, {1'b0, 24'h1CF134});
    tick();
    check("t1_busy", 32'(Adder_busy), 32'd1);
    wait_ack(1, lat);
    check("t1_latency", 32'(lat), 32'd4);
    score("t1", EXC_MADD_OK);
    release_valid();
    tick();
    check("t1_ack_pulse", 32'(Adder_ack), 32'd0);
    tick();
    check("t1_idle_busy", 32'(Adder_busy), 32'd0);

    // 2: carry ripples across every slice
    launch(24'hFFFFFF, 24'h000001, {1'b1, 24'h000000});
    wait_ack(0, lat);
    check("t2_latency", 32'(lat), 32'd4);
    score("t2", EXC_MADD_OK);
    release_valid();
    repeat (2) tick();

    // 3: MSB carry, then valid held past ack must not relaunch
    launch(24'h800000, 24'h800000, {1'b1, 24'h000000});
    wait_ack(0, lat);
    score("t3", EXC_MADD_OK);
    tick();
    check("t3_hold_ack1", 32'(Adder_ack), 32'd0);
    tick();
    check("t3_hold_ack2", 32'(Adder_ack), 32'd0);
    check("t3_hold_state", 32'(dbg_state), 32'(WAIT_LOW));
    release_valid();
    tick();
    check("t3_idle_busy", 32'(Adder_busy), 32'd0);
    tick();
    check("t3_no_relaunch", 32'(Adder_ack), 32'd0);

    // 4: operand change mid-add keeps captured values and flags it
    launch(24'h000010, 24'h000020, {1'b0, 24'h000030});
    tick();
    @(negedge CLK);
    Adder_datain2 = 24'h000030;
    wait_ack(1, lat);
    check("t4_latency", 32'(lat), 32'd4);
    score("t4", EXC_MADD_UNSTABLE);
    release_valid();
    repeat (2) tick();

    // 5: abort after the first ADD edge, then a clean request
    @(negedge CLK);
    Adder_datain1 = 24'h00FF00;
    Adder_datain2 = 24'h000100;
    Adder_valid   = 1'b1;
    repeat (2) tick();
    release_valid();
    tick();
    check("t5_abort_busy", 32'(Adder_busy), 32'd0);
    check("t5_abort_ack",  32'(Adder_ack), 32'd0);
    check("t5_abort_state", 32'(dbg_state), 32'(IDLE));
    launch(24'h00FF00, 24'h000100, {1'b0, 24'h010000});
    wait_ack(0, lat);
    check("t5_latency", 32'(lat), 32'd4);
    score("t5", EXC_MADD_OK);
    release_valid();
    repeat (2) tick();

    // 6: asynchronous reset between edges mid-add
    launch(24'h0F0F0F, 24'h010101, {1'b0, 24'h101010});
    repeat (2) tick();
    #2;
    RSTn = 1'b0;
    #1;
    check("t6_rst_dataout", 32'(Adder_dataout), 32'd0);
    check("t6_rst_busy",    32'(Adder_busy), 32'd0);
    check("t6_rst_ack",     32'(Adder_ack), 32'd0);
    check("t6_rst_carry",   32'(Adder_carryout), 32'd0);
    check("t6_rst_state",   32'(dbg_state), 32'(IDLE));
    void'(exp_q.pop_back());
    @(negedge CLK);
    Adder_valid = 1'b0;
    RSTn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t6_no_ack", 32'(Adder_ack), 32'd0);
    end
    launch(24'h0F0F0F, 24'h010101, {1'b0, 24'h101010});
    wait_ack(0, lat);
    score("t6_after", EXC_MADD_OK);
    release_valid();
    repeat (2) tick();

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
